// File: rtl/scr1_clk_gate_ctrl_if.sv
// Sleep/wake handshake and clock-gate enable signals between the core and the gate controller.
// The slave modport is the controller's view; the master modport is the core's view.
interface scr1_clk_gate_ctrl_if;
  logic       sleep_req;
  logic       core_idle;
  logic       wake_evt;
  logic       test_mode;
  logic       clk_en;
  logic       sleep_ack;
  logic       wakeup;
  logic       sleep_abort;
  logic [1:0] state_o;

  modport slave (
    input  sleep_req,
    input  core_idle,
    input  wake_evt,
    input  test_mode,
    output clk_en,
    output sleep_ack,
    output wakeup,
    output sleep_abort,
    output state_o
  );

  modport master (
    output sleep_req,
    output core_idle,
    output wake_evt,
    output test_mode,
    input  clk_en,
    input  sleep_ack,
    input  wakeup,
    input  sleep_abort,
    input  state_o
  );
endinterface

// File: rtl/scr1_clk_gate_ctrl.sv
// Core clock-gate enable controller: gates after a qualified idle period following a sleep
// request, and ungates on wake while holding sleep_ack for a short settle window.
module scr1_clk_gate_ctrl #(
  parameter int IDLE_DLY = 4,
  parameter int WAKE_DLY = 2,
  parameter int CNT_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  scr1_clk_gate_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_DLY - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_DLY - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             clk_en_reg, clk_en_next;
  logic             sleep_ack_reg, sleep_ack_next;
  logic             wakeup_reg, wakeup_next;
  logic             sleep_abort_reg, sleep_abort_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      cnt_reg         <= '0;
      clk_en_reg      <= 1'b1;
      sleep_ack_reg   <= 1'b0;
      wakeup_reg      <= 1'b0;
      sleep_abort_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      clk_en_reg      <= clk_en_next;
      sleep_ack_reg   <= sleep_ack_next;
      wakeup_reg      <= wakeup_next;
      sleep_abort_reg <= sleep_abort_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    clk_en_next      = 1'b1;
    sleep_ack_next   = 1'b0;
    wakeup_next      = 1'b0;
    sleep_abort_next = 1'b0;

    unique case (state_reg)
      ST_RUN: begin
        if (bus.sleep_req && !bus.wake_evt) begin
          state_next = ST_DRAIN;
          cnt_next   = IDLE_LOAD;
        end
      end

      ST_DRAIN: begin
        // A wake or withdrawn request beats idle completion on the same edge.
        if (bus.wake_evt || !bus.sleep_req) begin
          state_next       = ST_RUN;
          sleep_abort_next = 1'b1;
        end else if (!bus.core_idle) begin
          cnt_next = IDLE_LOAD;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          state_next     = ST_SLEEP;
          clk_en_next    = 1'b0;
          sleep_ack_next = 1'b1;
        end
      end

      ST_SLEEP: begin
        sleep_ack_next = 1'b1;
        if (bus.wake_evt || !bus.sleep_req) begin
          state_next  = ST_WAKE;
          cnt_next    = WAKE_LOAD;
        end else begin
          clk_en_next = 1'b0;
        end
      end

      ST_WAKE: begin
        // Requests are ignored here so the core always gets a full settle window.
        if (cnt_reg == '0) begin
          state_next  = ST_RUN;
          wakeup_next = 1'b1;
        end else begin
          cnt_next       = cnt_reg - CNT_W'(1);
          sleep_ack_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign bus.clk_en      = clk_en_reg | bus.test_mode;
  assign bus.sleep_ack   = sleep_ack_reg;
  assign bus.wakeup      = wakeup_reg;
  assign bus.sleep_abort = sleep_abort_reg;
  assign bus.state_o     = state_reg;

endmodule

// File: tb/tb_scr1_clk_gate_ctrl.sv
// Directed bench for the clock-gate controller: sleep entry, wake, idle reload, abort race,
// DFT override and reset out of SLEEP, with hand-computed expectations.
module tb_scr1_clk_gate_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  scr1_clk_gate_ctrl_if bus_if();

  scr1_clk_gate_ctrl #(
    .IDLE_DLY (4),
    .WAKE_DLY (2),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  // Advance one clock edge; outputs settle by #1 and inputs are changed afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    chk("no_wakeup_with_abort", 32'(bus_if.wakeup & bus_if.sleep_abort), 32'd0);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] st, input logic en, input logic ack);
    chk({tag, "_state"}, 32'(bus_if.state_o), 32'(st));
    chk({tag, "_clk_en"}, 32'(bus_if.clk_en), 32'(en));
    chk({tag, "_ack"}, 32'(bus_if.sleep_ack), 32'(ack));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_if.sleep_req = 1'b0;
    bus_if.core_idle = 1'b0;
    bus_if.wake_evt  = 1'b0;
    bus_if.test_mode = 1'b0;
    step();
    step();
    chk_state("reset", 2'd0, 1'b1, 1'b0);
    chk("reset_wakeup", 32'(bus_if.wakeup), 32'd0);
    chk("reset_abort", 32'(bus_if.sleep_abort), 32'd0);

    // Sleep entry: DRAIN after 1 edge, SLEEP after the 4th idle edge.
    rst = 1'b0;
    bus_if.sleep_req = 1'b1;
    bus_if.core_idle = 1'b1;
    step();
    chk_state("entry_c1", 2'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_state($sformatf("entry_c%0d", i), 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_state("entry_c5", 2'd2, 1'b0, 1'b1);

    // Wake pulse: two WAKE cycles, then RUN with a single wakeup pulse.
    bus_if.wake_evt = 1'b1;
    step();
    chk_state("wake_w1", 2'd3, 1'b1, 1'b1);
    bus_if.wake_evt = 1'b0;
    step();
    chk_state("wake_w2", 2'd3, 1'b1, 1'b1);
    chk("wake_w2_wakeup", 32'(bus_if.wakeup), 32'd0);
    step();
    chk_state("wake_run", 2'd0, 1'b1, 1'b0);
    chk("wake_run_wakeup", 32'(bus_if.wakeup), 32'd1);
    step();
    chk_state("reenter_drain", 2'd1, 1'b1, 1'b0);
    chk("wakeup_single", 32'(bus_if.wakeup), 32'd0);

    // Idle drop at cnt=2 reloads to 3; SLEEP after exactly 4 idle edges from restore.
    step();
    chk("drain_cnt2", 32'(bus_if.state_o), 32'd1);
    bus_if.core_idle = 1'b0;
    step();
    chk("drain_reload", 32'(bus_if.state_o), 32'd1);
    bus_if.core_idle = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("restore_c%0d", i), 32'(bus_if.state_o), 32'd1);
    end
    step();
    chk_state("restore_c4", 2'd2, 1'b0, 1'b1);

    // Withdrawing sleep_req also wakes; WAKE ignores the request level.
    bus_if.sleep_req = 1'b0;
    step();
    chk_state("req_drop_w1", 2'd3, 1'b1, 1'b1);
    step();
    chk("req_drop_w2", 32'(bus_if.state_o), 32'd3);
    step();
    chk("req_drop_run", 32'(bus_if.state_o), 32'd0);
    chk("req_drop_wakeup", 32'(bus_if.wakeup), 32'd1);
    step();
    chk("run_hold", 32'(bus_if.state_o), 32'd0);

    // Wake on the edge where cnt==0 must abort, and clk_en never drops.
    bus_if.sleep_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("race_c%0d", i), 2'd1, 1'b1, 1'b0);
    end
    bus_if.wake_evt = 1'b1;
    step();
    chk_state("race_abort", 2'd0, 1'b1, 1'b0);
    chk("race_abort_pulse", 32'(bus_if.sleep_abort), 32'd1);
    bus_if.wake_evt  = 1'b0;
    bus_if.sleep_req = 1'b0;
    step();
    chk_state("race_after", 2'd0, 1'b1, 1'b0);
    chk("race_abort_single", 32'(bus_if.sleep_abort), 32'd0);

    // test_mode forces clk_en combinationally without touching state.
    bus_if.sleep_req = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk_state("tm_sleep", 2'd2, 1'b0, 1'b1);
    bus_if.test_mode = 1'b1;
    #1;
    chk_state("tm_on", 2'd2, 1'b1, 1'b1);
    step();
    chk_state("tm_on_edge", 2'd2, 1'b1, 1'b1);
    bus_if.test_mode = 1'b0;
    #1;
    chk_state("tm_off", 2'd2, 1'b0, 1'b1);

    // Reset out of SLEEP: back to RUN, clock ungated, no wakeup pulse.
    rst = 1'b1;
    step();
    chk_state("rst_sleep", 2'd0, 1'b1, 1'b0);
    chk("rst_sleep_wakeup", 32'(bus_if.wakeup), 32'd0);
    rst = 1'b0;
    bus_if.sleep_req = 1'b0;
    step();
    chk_state("rst_release", 2'd0, 1'b1, 1'b0);
    chk("rst_release_wakeup", 32'(bus_if.wakeup), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scr1_clk_gate_ctrl.md
Name: scr1_clk_gate_ctrl

Overview:
Clock-gate enable controller that produces the clk_en input of the core clock gate primitive and runs the sleep/wake handshake with the core. It runs on the free-running (ungated) clock. It gates the core clock only after a sleep request and a stable idle indication, and ungates on a wake event. After ungating it holds sleep_ack for a settle period so the core sees a clean restart.

Parameters:
IDLE_DLY, 4, consecutive cycles core_idle must be high in DRAIN before gating; legal range 1..2**CNT_W
WAKE_DLY, 2, cycles clk_en is high in WAKE before sleep_ack drops; legal range 1..2**CNT_W
CNT_W, 4, width of the shared delay counter

Ports:
clk  in  1  free-running clock; the single clock domain of this block
rst  in  1  synchronous reset, active-high
sleep_req  in  1  core requests sleep (WFI retired); level, held until sleep_ack or abort
core_idle  in  1  pipeline drained, no outstanding bus transactions
wake_evt  in  1  wake source (pending IRQ or debug request); level
test_mode  in  1  DFT override; forces clk_en high
clk_en  out  1  enable to clock gate primitive
sleep_ack  out  1  high from entry to SLEEP until exit from WAKE
wakeup  out  1  one-cycle pulse on the WAKE->RUN transition
sleep_abort  out  1  one-cycle pulse when DRAIN aborts back to RUN
state_o  out  2  current state: RUN=0, DRAIN=1, SLEEP=2, WAKE=3

Behaviour:
- Behaviour at reset (rst=1 at a clk edge): state=RUN, cnt=0, clk_en_r=1, sleep_ack=0, wakeup=0, sleep_abort=0. Reset mid-operation, including in SLEEP, returns to RUN with clk_en=1 on the next cycle.
- Output timing: all outputs are registered except clk_en = clk_en_r | test_mode. test_mode is combinational and does not change state.
- RUN:
  - If sleep_req=1 and wake_evt=0: go to DRAIN and load cnt=IDLE_DLY-1.
  - If sleep_req=1 and wake_evt=1: stay in RUN.
- DRAIN, priority order:
  1. wake_evt=1 or sleep_req=0: go to RUN and pulse sleep_abort for one cycle.
  2. core_idle=0: reload cnt=IDLE_DLY-1 and stay in DRAIN.
  3. core_idle=1 and cnt!=0: decrement cnt.
  4. core_idle=1 and cnt==0: go to SLEEP. clk_en_r=0 and sleep_ack=1 in the same edge.
  - Result: gating occurs on the IDLE_DLY-th consecutive idle cycle. With IDLE_DLY=1, the first idle cycle gates.
- SLEEP:
  - clk_en_r=0 and sleep_ack=1.
  - If wake_evt=1 or sleep_req=0: go to WAKE, set clk_en_r=1 and load cnt=WAKE_DLY-1.
  - core_idle is ignored in SLEEP.
- WAKE:
  - clk_en_r=1 and sleep_ack=1.
  - cnt decrements each cycle. At cnt==0: go to RUN, sleep_ack=0, and pulse wakeup for one cycle.
  - wake_evt and sleep_req are ignored until RUN is reached.
  - In RUN, sleep_req still high re-enters DRAIN on the next edge. This is legal.
- Counter: unsigned CNT_W-bit. It never underflows because decrement only occurs when cnt!=0.
- Invariants:
  - clk_en_r=0 only in SLEEP.
  - sleep_ack=1 only in SLEEP or WAKE.
  - wakeup and sleep_abort are never high together.
- Simultaneous events: wake_evt has priority over idle completion in DRAIN. If wake_evt=1 on the same edge that cnt reaches 0, the result is an abort, not SLEEP.

Test Plan:
- Defaults. rst=1 for 2 cycles, release, sleep_req=1, core_idle=1 from cycle 0 -> DRAIN at cycle 1; SLEEP with clk_en=0 and sleep_ack=1 after the 4th idle cycle, i.e. state_o=2 at cycle 5.
- In SLEEP, assert wake_evt for 1 cycle -> clk_en=1 on the next cycle, state_o=3 for 2 cycles, then state_o=0 with sleep_ack=0 and a single-cycle wakeup=1.
- In DRAIN with cnt=2, drop core_idle for 1 cycle and restore it -> cnt reloads to 3; SLEEP is reached 4 idle cycles after restore.
- In DRAIN, assert wake_evt on the cycle cnt==0 -> returns to RUN, sleep_abort=1 for 1 cycle, clk_en never drops.
- In SLEEP, assert test_mode=1 -> clk_en=1 combinationally while state_o stays 2; deassert -> clk_en=0 again.
- In SLEEP, assert rst=1 -> next cycle state_o=0, clk_en=1, sleep_ack=0, no wakeup pulse.
